debounce: RTL and testbench

Push-button debouncer for front-panel key inputs. It synchronises a raw, bouncing mechanical key into the clock domain and filters it with a stability counter. It emits a single one-clock pulse on each debounced press (0->1). It sits between the board key pins and the control FSMs that consume key events.

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_sync_2ff.sv | 26 ++
 rtl/debounce.sv | 63 ++++++
 tb/tb_debounce.sv | 127 ++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Project-wide constants for front-panel key handling.
package debounce_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 8;
    localparam int unsigned CLK_HZ                  = 10_000_000;

    // Converts a debounce window in milliseconds to clock cycles at CLK_HZ.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs.
module debounce_sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] s1_q;
    logic [Width-1:0] s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/debounce.sv
// Key debouncer: synchronise, qualify with a stability counter, pulse once per press.
module debounce
    import debounce_pkg::*;
#(
    parameter  int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_pulse
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic             key_sync;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    debounce_sync_2ff #(
        .Width(1)
    ) u_sync (
        .clk_i (clk),
        .rst_ni(rst),
        .d_i   (key),
        .q_o   (key_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (key_sync != state_q) begin
            if (cnt_q == CntLast) begin
                state_d = key_sync;
                // Only the rising debounced transition is reported.
                pulse_d = key_sync;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign key_pulse = pulse_q;

endmodule

// File: tb/tb_debounce.sv
// Table-driven bench for the key debouncer plus glitch and async-reset sequences.
module tb_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key = 1'b0;
    logic key_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    always #50 clk = ~clk;

    debounce #(
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .key_pulse(key_pulse)
    );

    typedef struct {
        string name;
        logic  rst_v;
        logic  key_v;
        int    cycles;
        int    exp_cnt;
        int    exp_first;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Drive levels at a falling edge; edge index 0 is the next rising edge.
    task automatic run_seg(input string nm, input logic r, input logic k, input int cycles,
                           input int exp_cnt, input int exp_first);
        int cnt;
        int first;
        cnt   = 0;
        first = -1;
        @(negedge clk);
        rst = r;
        key = k;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (key_pulse === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
            end else if (key_pulse !== 1'b0) begin
                cnt += 100;
            end
        end
        check({nm, " pulse count"}, cnt, exp_cnt);
        if (exp_first >= 0) check({nm, " pulse edge"}, first, exp_first);
    endtask

    initial begin
        int gcnt;

        for (int i = 0; i < 10; i++) begin
            vecs.push_back('{"rst_hold", 1'b0, logic'(i % 2 == 0), 1, 0, -1});
        end
        vecs.push_back('{"rst_release",       1'b1, 1'b0, 5,  0, -1});
        vecs.push_back('{"clean_press",       1'b1, 1'b1, 20, 1, 9});
        vecs.push_back('{"clean_release",     1'b1, 1'b0, 20, 0, -1});
        vecs.push_back('{"bounce_hi",         1'b1, 1'b1, 4,  0, -1});
        vecs.push_back('{"bounce_lo",         1'b1, 1'b0, 2,  0, -1});
        vecs.push_back('{"bounce_final",      1'b1, 1'b1, 20, 1, 9});
        vecs.push_back('{"bounce_release",    1'b1, 1'b0, 20, 0, -1});
        vecs.push_back('{"long_hold",         1'b1, 1'b1, 50, 1, 9});
        vecs.push_back('{"long_release",      1'b1, 1'b0, 50, 0, -1});
        vecs.push_back('{"second_press",      1'b1, 1'b1, 20, 1, 9});
        vecs.push_back('{"second_release",    1'b1, 1'b0, 20, 0, -1});
        vecs.push_back('{"midcount_press",    1'b1, 1'b1, 5,  0, -1});
        vecs.push_back('{"midcount_rst",      1'b0, 1'b1, 2,  0, -1});
        vecs.push_back('{"requalify",         1'b1, 1'b1, 20, 1, 9});
        vecs.push_back('{"requalify_release", 1'b1, 1'b0, 20, 0, -1});

        #2 rst = 1'b0;
        #1 check("reset value", int'(key_pulse), 0);

        foreach (vecs[i]) begin
            run_seg(vecs[i].name, vecs[i].rst_v, vecs[i].key_v, vecs[i].cycles,
                    vecs[i].exp_cnt, vecs[i].exp_first);
        end

        // Sub-cycle glitches between rising edges, key ends low each time.
        gcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int g = 0; g < 8; g++) begin
                #5 key = ~key;
            end
            @(posedge clk);
            #1;
            if (key_pulse !== 1'b0) gcnt++;
        end
        check("glitch burst", gcnt, 0);
        run_seg("glitch_after", 1'b1, 1'b0, 12, 0, -1);

        // Asynchronous reset must clear a pulse mid-cycle.
        @(negedge clk);
        key = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("async pulse high", int'(key_pulse), 1);
        #10 rst = 1'b0;
        #1 check("async reset clears pulse", int'(key_pulse), 0);
        @(negedge clk);
        rst = 1'b1;
        key = 1'b0;
        run_seg("after_async_rst", 1'b1, 1'b0, 15, 0, -1);
        run_seg("press_after_async_rst", 1'b1, 1'b1, 20, 1, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
